// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: default geometry shared by the FIFO and its storage
package sync_fifo_pkg;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one write port and an asynchronous read port
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with exact full/empty flags
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int FIFO_WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  next_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_WIDTH-1:0] head;
  logic push, pop;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = next_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign push  = write_en && (!full || pop);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_WIDTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  assign data_out = empty ? '0 : head;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized scoreboard bench for sync_fifo against a queue model
module tb_sync_fifo;
  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  logic clk = 0, rst = 0, write_en = 0, next_en = 0;
  logic [WIDTH-1:0] data_in = '0, data_out;
  logic empty, full;
  logic [WIDTH-1:0] sb [$];
  int cmp = 0, bad = 0;

  sync_fifo #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
    .next_en(next_en), .data_out(data_out), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // monitor: flags every cycle; a pop handshake consumes the expected head word
  always @(negedge clk)
    if (rst) begin
      chk("empty_flag", empty, sb.size() == 0);
      chk("full_flag", full, sb.size() == DEPTH);
      if (sb.size() == 0) chk("data_out_empty", data_out, 0);
      else if (next_en) chk("pop_data", data_out, sb.pop_front());
    end

  // model: a push is accepted when there is room after this cycle's pop
  always @(posedge clk)
    if (rst && write_en && sb.size() < DEPTH) sb.push_back(data_in);

  task automatic cyc(input logic we, input logic [WIDTH-1:0] d, input logic ne);
    write_en = we;
    data_in  = d;
    next_en  = ne;
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) cyc(1, WIDTH'(i), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1);
  endtask

  initial begin
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_data", data_out, 0);
    @(posedge clk);
    #1 rst = 1;

    fill();
    chk("fill_full", full, 1);
    chk("fill_not_empty", empty, 0);
    drain();
    chk("drain_empty", empty, 1);

    fill();
    cyc(1, 8'hFF, 0);
    chk("drop_full", full, 1);
    chk("drop_head", data_out, 0);
    drain();

    fill();
    cyc(1, 8'h40, 1);
    chk("pushpop_full", full, 1);
    chk("pushpop_head", data_out, 1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 1);
    chk("pushpop_last", data_out, 8'h40);
    cyc(0, 0, 1);
    chk("pushpop_empty", empty, 1);

    cyc(0, 0, 1);
    chk("pop_empty_flag", empty, 1);
    chk("pop_empty_data", data_out, 0);
    cyc(1, 8'h11, 1);
    chk("push_pop_empty_data", data_out, 8'h11);
    chk("push_pop_empty_flag", empty, 0);
    cyc(0, 0, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 20; i++) cyc(1, WIDTH'($urandom_range(0, 255)), 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1);
    end
    chk("wrap_empty", empty, 1);

    for (int i = 0; i < 1500; i++) begin
      int bias = (i / 300) % 2 ? 70 : 30;
      cyc($urandom_range(0, 99) < 100 - bias, WIDTH'($urandom), $urandom_range(0, 99) < bias);
    end
    while (sb.size() > 5) cyc(0, 0, 1);
    while (sb.size() < 5) cyc(1, WIDTH'($urandom), 0);

    write_en = 0;
    #2 rst = 0;
    sb.delete();
    #1;
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_data", data_out, 0);
    @(posedge clk);
    #1 rst = 1;
    cyc(1, 8'hA5, 0);
    chk("after_rst_data", data_out, 8'hA5);
    chk("after_rst_empty", empty, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, first-word-fall-through FIFO buffering FIFO_WIDTH-bit words between a producer and a consumer inside the TPU datapath. Words are pushed with `write_en` and popped with `next_en`. The head word is always visible on `data_out` without a read latency. `full` and `empty` flags are exact and give back-pressure to both sides.

## Interface
Parameters:
- FIFO_DEPTH, 32: number of storage entries; power of two, ≥ 2.
- FIFO_WIDTH, 8: word width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- data_in  input  FIFO_WIDTH  word to push.
- write_en  input  1  push request, sampled at the rising edge.
- next_en  input  1  pop request; advances the head at the rising edge.
- data_out  output  FIFO_WIDTH  current head word (combinational from storage and pointers).
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds FIFO_DEPTH words.

## Operation
- State:
  - Storage array of FIFO_DEPTH × FIFO_WIDTH.
  - Write and read pointers, each $clog2(FIFO_DEPTH)+1 bits wide. The MSB is a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (index bits equal) and (wrap bits differ).
- Push accepted = write_en && (!full || pop accepted):
  - mem[wr_ptr index] <= data_in.
  - wr_ptr increments modulo 2·FIFO_DEPTH.
- Pop accepted = next_en && !empty:
  - rd_ptr increments modulo 2·FIFO_DEPTH.
- data_out = mem[rd_ptr index] when !empty; otherwise 0.
- Boundary rules:
  - Push while full with no pop: dropped silently. Pointers, storage and flags are unchanged.
  - Pop while empty: ignored. This includes a simultaneous push into an empty FIFO, where the push is accepted and the pop is ignored.
  - Push and pop in the same cycle while full: both accepted. full stays 1.
  - Push and pop in the same cycle, neither empty nor full: occupancy is unchanged and both pointers advance.
  - Pointers wrap naturally and the wrap bit toggles. Pointer arithmetic never saturates.
- Reset is asserted when rst = 0 and takes effect immediately, independent of clk:
  - Both pointers are cleared.
  - empty = 1, full = 0, data_out = 0.
  - Storage contents are not cleared and are not observable after reset.
  - Reset asserted mid-operation discards all stored words.

## Timing
- Push latency: a word pushed at edge N is visible on data_out after edge N if the FIFO was empty. empty falls after edge N.
- Pop: after the edge that accepts a pop, data_out shows the next word, or 0 with empty = 1.
- full rises after the edge that accepts the FIFO_DEPTH-th word. It falls after the first edge that accepts a pop without a push.
- Flags derive combinationally from registered pointers. They carry no extra cycle of latency and no glitch-prone inputs.
- Throughput: one push and one pop per cycle, sustained.
- Release of rst is synchronous to clk in the surrounding design. The first edge after release may accept a push.

## Structure
- No shared-package typedefs are required.
- Pointer width is a localparam computed as $clog2(FIFO_DEPTH)+1.
- One sub-module is natural: `fifo_mem`. It is a parameterised register array with a write port and an asynchronous read port, so a macro RAM can be substituted later.
- Pointer and flag logic stays in `sync_fifo`.

## Test plan
- Reset (rst = 0) mid-run with 5 words stored → empty = 1, full = 0, data_out = 0 immediately. After release, one push of 8'hA5 → data_out = 8'hA5.
- Push 0..31 on 32 consecutive edges → full = 1, empty = 0. Then pop on 32 consecutive edges → data_out reads 0,1,…,31, one value per cycle, and empty = 1 after the last pop.
- With the FIFO full, push 8'hFF with next_en = 0 → word dropped. The subsequent 32 pops return 0..31 and never 8'hFF.
- With the FIFO full, push 8'h40 together with a pop → head advances, full stays 1, and 8'h40 is returned as the 32nd subsequent pop.
- On an empty FIFO, next_en = 1 alone → no change (empty = 1, data_out = 0). next_en plus a push of 8'h11 → data_out = 8'h11, empty = 0.
- Wrap: 20 pushes and 20 pops, repeated 4 times with random data → order preserved across pointer wrap, and flags correct at every cycle against a reference queue.
